multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS-subset controller: FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the shared-memory datapath.
//  Supports addu/subu/and/or/slt, ori, addiu, lw, sw, beq, j.
//  Adds a ready/timeout memory handshake, illegal-opcode trapping and a retire strobe.
// PARAMETERS
//  ALUCTR_W     3   width of alu_ctr
//  MEM_TIMEOUT  15  max wait cycles for mem_ready; 0 = wait forever
//  TRAP_EN      1   1: flag illegal op/func; 0: treat as NOP silently
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  reset; one clock; asynchronous, active-low
//  op          in   6  IR[31:26]; stable from DECODE until next FETCH
//  func        in   6  IR[5:0]; same stability rule
//  zero        in   1  ALU zero flag (beq)
//  mem_ready   in   1  memory completes current access this cycle
//  mem_req     out  1  memory access request, held until ready/timeout
//  mem_wr      out  1  write qualifier for mem_req
//  iord        out  1  0: address=PC, 1: address=ALUOut
//  ir_wr       out  1  load IR
//  pc_wr       out  1  load PC
//  pc_src      out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  alu_src_a   out  1  0: PC, 1: rs
//  alu_src_b   out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ext_op      out  1  1: sign-extend, 0: zero-extend
//  alu_ctr     out  ALUCTR_W  000 ADD, 001 SUB, 010 OR, 011 AND, 100 SLT
//  reg_wr      out  1  register file write
//  reg_dst     out  1  1: rd, 0: rt
//  mem_to_reg  out  1  1: MDR, 0: ALUOut
//  illegal     out  1  1-cycle pulse on undecodable op/func
//  bus_err     out  1  1-cycle pulse on memory timeout
//  retire      out  1  1-cycle pulse in the final cycle of each instruction
//  state       out  3  current state code (debug)
// BEHAVIOUR
//  While rst_n=0: state=FETCH, all outputs 0 (including mem_req), class reg and timer cleared.
//  Unlisted outputs are 0; alu_ctr defaults ADD.
//  FETCH: mem_req=1, iord=0, src_a=0, src_b=01, ADD. On mem_ready: ir_wr=1, pc_wr=1, pc_src=00 -> DECODE.
//  DECODE: src_a=0, src_b=11, ext_op=1, ADD (branch target). Registers instruction class from op/func.
//    j: pc_wr=1, pc_src=10, retire -> FETCH. Illegal: illegal=TRAP_EN, retire -> FETCH. Others -> EXEC.
//  EXEC:
//    R: src_a=1, src_b=00, alu_ctr per func -> WB.
//    ori: src_b=10, ext_op=0, OR -> WB.
//    addiu/lw/sw: src_b=10, ext_op=1, ADD. addiu -> WB; lw/sw -> MEM.
//    beq: src_a=1, src_b=00, SUB, pc_wr=zero, pc_src=01, retire -> FETCH.
//  MEM: mem_req=1, iord=1, mem_wr=sw. On mem_ready: sw retires -> FETCH; lw -> WB.
//  WB: reg_wr=1, reg_dst=R, mem_to_reg=lw, retire -> FETCH.
//  Func map: 100001 ADD, 100011 SUB, 100100 AND, 100101 OR, 101010 SLT; other funcs are illegal.
//  Minimum latency (no wait): j 2, beq 3, R/ori/addiu/sw 4, lw 5 cycles.
//  Timer:
//    Counts cycles in FETCH/MEM with mem_ready=0; clears on state change.
//    When timer==MEM_TIMEOUT-1 and ready still 0: bus_err=1, drop request, no ir/pc/reg write -> FETCH.
//    PC is unchanged, so the access retries.
//    mem_ready in the same cycle as the timeout condition wins (normal completion).
//  The registered class is used after DECODE, so op/func glitches after DECODE have no effect.
//  Async reset mid-access drops mem_req immediately.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/func localparams, ALUctr codes, pc_src/alu_src_b codes, state encoding.
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
//  Sub-module mc_ins_decoder: combinational op/func -> one-hot class + illegal flag.
//  Top level holds the FSM, class register, timeout counter and output decode.
// TESTING
//  1. addu (func 100001), ready always 1 -> states 0,1,2,4; ir_wr/pc_wr in cyc 0; alu_ctr 000 cyc 2; reg_wr,reg_dst=1 cyc 3; retire cyc 3.
//  2. lw, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_req/iord=1 held, then WB with mem_to_reg=1.
//  3. beq with zero=1 then zero=0 -> cyc 2: pc_wr=1,pc_src=01 vs pc_wr=0; both retire after 3 cycles.
//  4. MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err pulse after 4th wait cycle, ir_wr never asserted, re-enter FETCH.
//  5. op=111111, TRAP_EN=1 -> illegal pulse in DECODE, no reg_wr/mem_wr, FETCH next; TRAP_EN=0 -> no pulse.
//  6. rst_n low during MEM of sw -> mem_req, mem_wr drop same cycle; after release state=FETCH, mem_req=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funcs,
// ALU / mux select codes, FSM state codes and the decoded instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_TGT = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef struct packed {
    logic r;
    logic ori;
    logic addiu;
    logic lw;
    logic sw;
    logic beq;
    logic j;
  } ins_class_t;

endpackage

// File: rtl/mc_ins_decoder.sv
// Combinational op/func decode into a one-hot instruction class, the ALU code
// for R-type instructions and an illegal flag.
module mc_ins_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  output ins_class_t  cls,
  output logic [2:0]  r_alu,
  output logic        illegal
);

  always_comb begin
    cls     = '0;
    r_alu   = ALU_ADD;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls.r = 1'b1;
        case (func)
          FN_ADDU: r_alu = ALU_ADD;
          FN_SUBU: r_alu = ALU_SUB;
          FN_AND:  r_alu = ALU_AND;
          FN_OR:   r_alu = ALU_OR;
          FN_SLT:  r_alu = ALU_SLT;
          default: begin
            cls.r   = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ORI:   cls.ori   = 1'b1;
      OP_ADDIU: cls.addiu = 1'b1;
      OP_LW:    cls.lw    = 1'b1;
      OP_SW:    cls.sw    = 1'b1;
      OP_BEQ:   cls.beq   = 1'b1;
      OP_J:     cls.j     = 1'b1;
      default:  illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FSM, registered instruction class,
// memory wait timer and per-state datapath control decode.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC += 4 on completion
//   DECODE | compute branch target, latch class; j / illegal finish here
//   EXEC   | ALU operation or address calc; beq finishes here
//   MEM    | data read (lw) or write (sw) at ALUOut
//   WB     | register file write from ALUOut or MDR
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTR_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_wr,
  output logic                iord,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                reg_wr,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                bus_err,
  output logic                retire,
  output logic [2:0]          state
);

  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  ins_class_t        cls_q, cls_d;
  logic [2:0]        alu_q, alu_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  ins_class_t        dec_cls;
  logic [2:0]        dec_alu;
  logic              dec_ill;
  logic              wait_st;
  logic              timeout;

  mc_ins_decoder u_dec (
    .op      (op),
    .func    (func),
    .cls     (dec_cls),
    .r_alu   (dec_alu),
    .illegal (dec_ill)
  );

  assign wait_st = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // Down-counter reaching zero while still not ready is the timeout point.
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (tmr_q == '0);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= '0;
      alu_q   <= ALU_ADD;
      tmr_q   <= TMR_LOAD;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d   = dec_cls;
        alu_d   = dec_alu;
        state_d = (dec_cls.j || dec_ill) ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        if (cls_q.beq)                 state_d = ST_FETCH;
        else if (cls_q.lw || cls_q.sw) state_d = ST_MEM;
        else                           state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)    state_d = cls_q.lw ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_FETCH;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) || timeout || !wait_st) tmr_d = TMR_LOAD;
    else if (!mem_ready)                             tmr_d = tmr_q - TMR_W'(1);
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    ext_op     = 1'b0;
    alu_ctr    = ALUCTR_W'(ALU_ADD);
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    retire     = 1'b0;
    // Gating by rst_n drops the memory request the moment reset asserts.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req   = !timeout;
          alu_src_b = SRC_B_FOUR;
          ir_wr     = mem_ready;
          pc_wr     = mem_ready;
          bus_err   = timeout;
        end
        ST_DECODE: begin
          alu_src_b = SRC_B_IMM_SL2;
          ext_op    = 1'b1;
          if (dec_cls.j) begin
            pc_wr  = 1'b1;
            pc_src = PC_SRC_JMP;
            retire = 1'b1;
          end
          if (dec_ill) begin
            illegal = TRAP_EN;
            retire  = 1'b1;
          end
        end
        ST_EXEC: begin
          if (cls_q.r) begin
            alu_src_a = 1'b1;
            alu_ctr   = ALUCTR_W'(alu_q);
          end
          if (cls_q.ori) begin
            alu_src_b = SRC_B_IMM;
            alu_ctr   = ALUCTR_W'(ALU_OR);
          end
          if (cls_q.addiu || cls_q.lw || cls_q.sw) begin
            alu_src_b = SRC_B_IMM;
            ext_op    = 1'b1;
          end
          if (cls_q.beq) begin
            alu_src_a = 1'b1;
            alu_ctr   = ALUCTR_W'(ALU_SUB);
            pc_wr     = zero;
            pc_src    = PC_SRC_TGT;
            retire    = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req = !timeout;
          iord    = 1'b1;
          mem_wr  = cls_q.sw && !timeout;
          bus_err = timeout;
          retire  = cls_q.sw && mem_ready;
        end
        ST_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = cls_q.r;
          mem_to_reg = cls_q.lw;
          retire     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-level phase model
// predicts every control output each cycle, plus directed corner cases.
module tb_multicycle_ctrl;

  localparam int TMO = 4;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  typedef enum int {
    K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_ORI, K_ADDIU,
    K_LW, K_SW, K_BEQ, K_J, K_BADOP, K_BADFN
  } kind_t;

  logic       clk, rst_n;
  logic [5:0] op, func;
  logic       zero, mem_ready;

  logic       mem_req, mem_wr, iord, ir_wr, pc_wr, alu_src_a, ext_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctr, state;
  logic       reg_wr, reg_dst, mem_to_reg, illegal, bus_err, retire;

  logic       mem_req_b, mem_wr_b, iord_b, ir_wr_b, pc_wr_b, alu_src_a_b, ext_op_b;
  logic [1:0] pc_src_b, alu_src_b_b;
  logic [2:0] alu_ctr_b, state_b;
  logic       reg_wr_b, reg_dst_b, mem_to_reg_b, illegal_b, bus_err_b, retire_b;

  wire [22:0] outs_a = {mem_req, mem_wr, iord, ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b,
                        ext_op, alu_ctr, reg_wr, reg_dst, mem_to_reg, illegal, bus_err, retire, state};
  wire [22:0] outs_b = {mem_req_b, mem_wr_b, iord_b, ir_wr_b, pc_wr_b, pc_src_b, alu_src_a_b,
                        alu_src_b_b, ext_op_b, alu_ctr_b, reg_wr_b, reg_dst_b, mem_to_reg_b,
                        illegal_b, bus_err_b, retire_b, state_b};

  multicycle_ctrl #(.ALUCTR_W(3), .MEM_TIMEOUT(TMO), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_ctr(alu_ctr), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .bus_err(bus_err), .retire(retire), .state(state)
  );

  multicycle_ctrl #(.ALUCTR_W(3), .MEM_TIMEOUT(TMO), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .mem_wr(mem_wr_b), .iord(iord_b), .ir_wr(ir_wr_b), .pc_wr(pc_wr_b),
    .pc_src(pc_src_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .ext_op(ext_op_b),
    .alu_ctr(alu_ctr_b), .reg_wr(reg_wr_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
    .illegal(illegal_b), .bus_err(bus_err_b), .retire(retire_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks, n_errors;
  kind_t m_kind;
  int    m_ph[$];
  int    m_idx, m_wait;
  bit    m_done;
  bit    g_dir;
  int    g_fstall, g_mstall;
  logic  g_zero;
  int    obs_retire, obs_bus_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ins_op(kind_t k);
    case (k)
      K_ORI:   return 6'b001101;
      K_ADDIU: return 6'b001001;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      K_J:     return 6'b000010;
      K_BADOP: return 6'b111111;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] ins_func(kind_t k);
    case (k)
      K_ADDU:  return 6'b100001;
      K_SUBU:  return 6'b100011;
      K_AND:   return 6'b100100;
      K_OR:    return 6'b100101;
      K_SLT:   return 6'b101010;
      K_BADFN: return 6'b100110;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] r_alu(kind_t k);
    case (k)
      K_SUBU:  return 3'b001;
      K_AND:   return 3'b011;
      K_OR:    return 3'b010;
      K_SLT:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Phase list of an instruction, straight from the per-class flow.
  function automatic void set_phases(kind_t k);
    m_ph = {PH_F, PH_D};
    if (k == K_J || k == K_BADOP || k == K_BADFN) return;
    m_ph.push_back(PH_E);
    if (k == K_LW || k == K_SW) m_ph.push_back(PH_M);
    if (k != K_BEQ && k != K_SW) m_ph.push_back(PH_W);
  endfunction

  task automatic step(input bit drain);
    int   ph;
    logic rdy, z, to, is_r, is_bad;
    logic e_req, e_wr, e_iord, e_irw, e_pcw, e_sa, e_ext, e_rw, e_rd, e_m2r, e_ill, e_be, e_ret;
    logic [1:0] e_pcs, e_sb;
    logic [2:0] e_alu;
    @(negedge clk);
    ph = m_ph[m_idx];
    if (ph == PH_F || ph == PH_M) begin
      if (drain)      rdy = 1'b1;
      else if (g_dir) rdy = (m_wait >= ((ph == PH_F) ? g_fstall : g_mstall));
      else            rdy = ($urandom_range(0, 99) < 55);
    end else rdy = 1'($urandom);
    z = g_dir ? g_zero : 1'($urandom);
    mem_ready = rdy;
    zero      = z;
    if (ph == PH_D) begin
      op   = ins_op(m_kind);
      func = ins_func(m_kind);
    end else begin
      op   = 6'($urandom);
      func = 6'($urandom);
    end
    #1;
    is_r   = m_kind inside {K_ADDU, K_SUBU, K_AND, K_OR, K_SLT};
    is_bad = m_kind inside {K_BADOP, K_BADFN};
    to     = (ph == PH_F || ph == PH_M) && !rdy && (m_wait == TMO - 1);
    {e_req, e_wr, e_iord, e_irw, e_pcw, e_sa, e_ext, e_rw, e_rd, e_m2r, e_ill, e_be, e_ret} = '0;
    e_pcs = 2'b00; e_sb = 2'b00; e_alu = 3'b000;
    case (ph)
      PH_F: begin
        e_req = !to; e_sb = 2'b01; e_irw = rdy; e_pcw = rdy; e_be = to;
      end
      PH_D: begin
        e_sb = 2'b11; e_ext = 1'b1;
        if (m_kind == K_J) begin e_pcw = 1'b1; e_pcs = 2'b10; e_ret = 1'b1; end
        if (is_bad) begin e_ill = 1'b1; e_ret = 1'b1; end
      end
      PH_E: begin
        if (is_r) begin e_sa = 1'b1; e_alu = r_alu(m_kind); end
        else if (m_kind == K_ORI) begin e_sb = 2'b10; e_alu = 3'b010; end
        else if (m_kind inside {K_ADDIU, K_LW, K_SW}) begin e_sb = 2'b10; e_ext = 1'b1; end
        else if (m_kind == K_BEQ) begin
          e_sa = 1'b1; e_alu = 3'b001; e_pcw = z; e_pcs = 2'b01; e_ret = 1'b1;
        end
      end
      PH_M: begin
        e_req = !to; e_iord = 1'b1; e_wr = (m_kind == K_SW) && !to;
        e_ret = (m_kind == K_SW) && rdy; e_be = to;
      end
      default: begin
        e_rw = 1'b1; e_rd = is_r; e_m2r = (m_kind == K_LW); e_ret = 1'b1;
      end
    endcase
    check_eq("state", 32'(state), 32'(ph));
    check_eq("mem_req", 32'(mem_req), 32'(e_req));
    check_eq("mem_wr", 32'(mem_wr), 32'(e_wr));
    check_eq("iord", 32'(iord), 32'(e_iord));
    check_eq("ir_wr", 32'(ir_wr), 32'(e_irw));
    check_eq("pc_wr", 32'(pc_wr), 32'(e_pcw));
    check_eq("pc_src", 32'(pc_src), 32'(e_pcs));
    check_eq("alu_src_a", 32'(alu_src_a), 32'(e_sa));
    check_eq("alu_src_b", 32'(alu_src_b), 32'(e_sb));
    check_eq("ext_op", 32'(ext_op), 32'(e_ext));
    check_eq("alu_ctr", 32'(alu_ctr), 32'(e_alu));
    check_eq("reg_wr", 32'(reg_wr), 32'(e_rw));
    check_eq("reg_dst", 32'(reg_dst), 32'(e_rd));
    check_eq("mem_to_reg", 32'(mem_to_reg), 32'(e_m2r));
    check_eq("illegal", 32'(illegal), 32'(e_ill));
    check_eq("bus_err", 32'(bus_err), 32'(e_be));
    check_eq("retire", 32'(retire), 32'(e_ret));
    check_eq("nt_state", 32'(state_b), 32'(ph));
    check_eq("nt_illegal", 32'(illegal_b), 32'(0));
    check_eq("nt_retire", 32'(retire_b), 32'(e_ret));
    check_eq("nt_reg_wr", 32'(reg_wr_b), 32'(e_rw));
    if (retire)  obs_retire++;
    if (bus_err) obs_bus_err++;
    if ((ph == PH_F || ph == PH_M) && !rdy) begin
      if (to) begin m_idx = 0; m_wait = 0; end
      else m_wait++;
    end else begin
      m_wait = 0;
      m_idx++;
      if (m_idx == m_ph.size()) begin m_done = 1'b1; m_idx = 0; end
    end
  endtask

  task automatic run_ins(input kind_t k, input int fst, input int mst, input logic z,
                         input bit dir, input int max_cyc, input bit drain_en,
                         input int exp_ret, input int exp_bus, input string tag);
    int r0, b0;
    m_kind = k; set_phases(k); m_idx = 0; m_wait = 0; m_done = 1'b0;
    g_dir = dir; g_fstall = fst; g_mstall = mst; g_zero = z;
    r0 = obs_retire; b0 = obs_bus_err;
    for (int c = 0; c < max_cyc && !m_done; c++) step(drain_en && (c >= max_cyc - 8));
    if (exp_ret >= 0) check_eq({tag, "_retires"}, 32'(obs_retire - r0), 32'(exp_ret));
    if (exp_bus >= 0) check_eq({tag, "_bus_errs"}, 32'(obs_bus_err - b0), 32'(exp_bus));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; obs_retire = 0; obs_bus_err = 0;
    rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs", 32'(outs_a), 32'(0));
    check_eq("rst_outs_nt", 32'(outs_b), 32'(0));
    rst_n = 1'b1;

    run_ins(K_ADDU, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "addu");
    run_ins(K_LW, 0, 3, 1'b0, 1'b1, 20, 1'b0, 1, 0, "lw_wait");
    run_ins(K_BEQ, 0, 0, 1'b1, 1'b1, 10, 1'b0, 1, 0, "beq_taken");
    run_ins(K_BEQ, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "beq_not");
    run_ins(K_J, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "jump");
    run_ins(K_ADDU, TMO, 0, 1'b0, 1'b1, 2 * TMO, 1'b0, 0, 2, "fetch_tmo");
    run_ins(K_ADDU, TMO - 1, 0, 1'b0, 1'b1, 20, 1'b0, 1, 0, "ready_at_limit");
    run_ins(K_SW, 0, TMO, 1'b0, 1'b1, 3 + TMO, 1'b0, 0, 1, "mem_tmo");
    run_ins(K_BADOP, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "bad_op");
    run_ins(K_BADFN, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "bad_func");

    // Reset asserted while sw waits in MEM.
    run_ins(K_SW, 0, 99, 1'b0, 1'b1, 4, 1'b0, 0, 0, "sw_pre_rst");
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_eq("sw_mem_req", 32'(mem_req), 32'(1));
    check_eq("sw_mem_wr", 32'(mem_wr), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_outs", 32'(outs_a), 32'(0));
    check_eq("mid_rst_outs_nt", 32'(outs_b), 32'(0));
    @(posedge clk);
    #1;
    check_eq("held_rst_outs", 32'(outs_a), 32'(0));
    rst_n = 1'b1;
    run_ins(K_ORI, 0, 0, 1'b0, 1'b1, 10, 1'b0, 1, 0, "post_rst");

    for (int i = 0; i < 300; i++)
      run_ins(kind_t'($urandom_range(0, 12)), 0, 0, 1'b0, 1'b0, 60, 1'b1, 1, -1, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
